// File: rtl/cc_branch_unit.sv
// cc_branch_unit: NZP condition code, branch resolve and CC save/restore stack.
// Define CC_FORWARD_EN to let a same-cycle writeback feed the branch decision.
module cc_branch_unit #(
    parameter int DATA_W      = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clka,
    input  logic                           reset_in,
    input  logic [DATA_W-1:0]              alu_result_in,
    input  logic                           we_reg_in,
    input  logic                           n_dec_in,
    input  logic                           z_dec_in,
    input  logic                           p_dec_in,
    input  logic                           br_valid_in,
    input  logic                           cc_push_in,
    input  logic                           cc_pop_in,
    output logic                           pc_ctl_0_out,
    output logic                           br_done_out,
    output logic [2:0]                     state_out,
    output logic [$clog2(STACK_DEPTH):0]   stack_count_out,
    output logic                           stack_full_out,
    output logic                           stack_empty_out,
    output logic                           stack_err_out
);
    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);
    localparam logic [2:0] CC_IDLE = 3'b000;
    localparam logic [2:0] CC_P    = 3'b001;
    localparam logic [2:0] CC_Z    = 3'b010;
    localparam logic [2:0] CC_N    = 3'b100;

    logic [2:0]    cc_q, cc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pc_q, pc_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [STACK_DEPTH];

    logic [2:0]    new_cc, eval_cc, mask;
    logic          full, empty, push_only, pop_only, do_push, do_pop, taken;
    logic [CW-1:0] cnt_m1;
    logic [AW-1:0] push_idx, pop_idx;

    always_comb begin
        new_cc    = alu_result_in[DATA_W-1] ? CC_N : (alu_result_in == '0) ? CC_Z : CC_P;
        full      = cnt_q == FULL_CNT;
        empty     = cnt_q == '0;
        push_only = cc_push_in & ~cc_pop_in;
        pop_only  = cc_pop_in & ~cc_push_in;
        do_push   = push_only & ~full;
        do_pop    = pop_only & ~empty;
        cnt_m1    = cnt_q - CW'(1);
        push_idx  = cnt_q[AW-1:0];
        pop_idx   = cnt_m1[AW-1:0];
        mask      = {n_dec_in, z_dec_in, p_dec_in};
`ifdef CC_FORWARD_EN
        eval_cc   = we_reg_in ? new_cc : cc_q;
`else
        eval_cc   = cc_q;
`endif
        taken     = (&mask) | (|(mask & eval_cc));
    end

    // Next-state: a writeback beats a pop for the CC, but the pop still consumes its slot.
    always_comb begin
        cc_d   = we_reg_in ? new_cc : do_pop ? stack_q[pop_idx] : cc_q;
        cnt_d  = do_push ? cnt_q + CW'(1) : do_pop ? cnt_m1 : cnt_q;
        err_d  = err_q | (push_only & full) | (pop_only & empty);
        pc_d   = br_valid_in ? taken : pc_q;
        done_d = br_valid_in;
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            cc_q   <= CC_IDLE;
            cnt_q  <= '0;
            pc_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cc_q   <= cc_d;
            cnt_q  <= cnt_d;
            pc_q   <= pc_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Slots are deliberately not reset; a slot is only read after it was pushed.
    always_ff @(posedge clka) begin
        if (!reset_in && do_push) stack_q[push_idx] <= cc_q;
    end

    always_comb begin
        state_out       = cc_q;
        pc_ctl_0_out    = pc_q;
        br_done_out     = done_q;
        stack_count_out = cnt_q;
        stack_full_out  = full;
        stack_empty_out = empty;
        stack_err_out   = err_q;
    end
endmodule

// File: tb/tb_cc_branch_unit.sv
// tb_cc_branch_unit: directed test-plan sequences plus randomized traffic checked
// against a symbolic CC / queue-based stack model.
module tb_cc_branch_unit;
    localparam int DW = 16;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst, we, n_dec, z_dec, p_dec, bv, push, pop;
    logic [DW-1:0] alu;
    logic          pc_o, done_o, full_o, empty_o, err_o;
    logic [2:0]    state_o;
    logic [2:0]    cnt_o;

    int errs = 0;
    int checks = 0;

    // Model: CC as a symbol 0=IDLE 1=P 2=Z 3=N, stack as a queue of symbols.
    int m_cc;
    int m_q[$];
    bit m_pc, m_done, m_err;

    cc_branch_unit #(.DATA_W(DW), .STACK_DEPTH(D)) dut (
        .clka(clk), .reset_in(rst), .alu_result_in(alu), .we_reg_in(we),
        .n_dec_in(n_dec), .z_dec_in(z_dec), .p_dec_in(p_dec), .br_valid_in(bv),
        .cc_push_in(push), .cc_pop_in(pop), .pc_ctl_0_out(pc_o), .br_done_out(done_o),
        .state_out(state_o), .stack_count_out(cnt_o), .stack_full_out(full_o),
        .stack_empty_out(empty_o), .stack_err_out(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [DW-1:0] a);
        if ($signed(a) < 0) return 3;
        if (a == 0) return 2;
        return 1;
    endfunction

    function automatic logic [2:0] onehot(input int s);
        logic [2:0] t [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        return t[s];
    endfunction

    function automatic bit br_taken(input logic [2:0] m, input int s);
        return (m == 3'b111) || (m[2] && s == 3) || (m[1] && s == 2) || (m[0] && s == 1);
    endfunction

    task automatic model_step();
        int nc, ev, v;
        if (rst) begin
            m_cc = 0; m_q.delete(); m_pc = 0; m_done = 0; m_err = 0;
            return;
        end
        nc = classify(alu);
        ev = m_cc;
`ifdef CC_FORWARD_EN
        if (we) ev = nc;
`endif
        m_done = bv;
        if (bv) m_pc = br_taken({n_dec, z_dec, p_dec}, ev);
        if (push && !pop) begin
            if (m_q.size() == D) m_err = 1; else m_q.push_back(m_cc);
        end
        if (pop && !push) begin
            if (m_q.size() == 0) m_err = 1;
            else begin
                v = m_q.pop_back();
                if (!we) m_cc = v;
            end
        end
        if (we) m_cc = nc;
    endtask

    task automatic cyc(input logic r, input logic w, input logic [DW-1:0] a,
                       input logic [2:0] m, input logic b, input logic ps, input logic pp);
        rst = r; we = w; alu = a; {n_dec, z_dec, p_dec} = m; bv = b; push = ps; pop = pp;
        @(posedge clk);
        model_step();
        #1;
        check("state", state_o, onehot(m_cc));
        check("pc", pc_o, m_pc);
        check("done", done_o, m_done);
        check("count", cnt_o, m_q.size());
        check("full", full_o, m_q.size() == D);
        check("empty", empty_o, m_q.size() == 0);
        check("err", err_o, m_err);
    endtask

    initial begin
        m_cc = 0; m_pc = 0; m_done = 0; m_err = 0;
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_state", state_o, 3'b000);
        check("rst_empty", empty_o, 1'b1);
        // Branches from IDLE
        cyc(0, 0, 0, 3'b111, 1, 0, 0);
        check("idle_111_pc", pc_o, 1'b1);
        check("idle_111_done", done_o, 1'b1);
        cyc(0, 0, 0, 3'b010, 1, 0, 0);
        check("idle_010_pc", pc_o, 1'b0);
        check("idle_010_done", done_o, 1'b1);
        cyc(0, 0, 0, 3'b000, 0, 0, 0);
        check("done_drop", done_o, 1'b0);
        check("pc_hold", pc_o, 1'b0);
        // N, Z, P classification
        cyc(0, 1, 16'h8000, 0, 0, 0, 0);
        check("cls_n", state_o, 3'b100);
        cyc(0, 1, 16'h0000, 0, 0, 0, 0);
        check("cls_z", state_o, 3'b010);
        cyc(0, 1, 16'h0001, 0, 0, 0, 0);
        check("cls_p", state_o, 3'b001);
        cyc(0, 0, 0, 3'b001, 1, 0, 0);
        check("br_p_taken", pc_o, 1'b1);
        // Writeback and branch in the same cycle
        cyc(0, 1, 16'h0005, 0, 0, 0, 0);
        cyc(0, 1, 16'h0000, 3'b010, 1, 0, 0);
`ifdef CC_FORWARD_EN
        check("fwd_pc", pc_o, 1'b1);
`else
        check("nofwd_pc", pc_o, 1'b0);
`endif
        // Push P, overwrite with N, pop restores P
        cyc(0, 1, 16'h0005, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        check("push_cnt", cnt_o, 3'd1);
        cyc(0, 1, 16'hFFFF, 0, 0, 0, 0);
        check("ovr_n", state_o, 3'b100);
        cyc(0, 0, 0, 0, 0, 0, 1);
        check("pop_state", state_o, 3'b001);
        check("pop_cnt", cnt_o, 3'd0);
        check("pop_err", err_o, 1'b0);
        // Overflow and underflow
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 0);
        check("ovf_cnt", cnt_o, 3'd4);
        check("ovf_full", full_o, 1'b1);
        check("ovf_err", err_o, 1'b1);
        cyc(0, 1, 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        check("unf_cnt", cnt_o, 3'd0);
        check("unf_empty", empty_o, 1'b1);
        check("unf_err", err_o, 1'b1);
        check("unf_state", state_o, 3'b001);
        // Push and pop together leave stack alone
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 16'h8001, 0, 0, 1, 1);
        check("pp_cnt", cnt_o, 3'd1);
        check("pp_state", state_o, 3'b100);
        // Mid-sequence reset with a branch in flight
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(1, 0, 0, 3'b111, 1, 0, 0);
        check("mrst_cnt", cnt_o, 3'd0);
        check("mrst_state", state_o, 3'b000);
        check("mrst_done", done_o, 1'b0);
        check("mrst_err", err_o, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("mrst_nopulse", done_o, 1'b0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [DW-1:0] a;
            int k;
            k = $urandom_range(0, 2);
            a = (k == 0) ? '0 : (k == 1) ? DW'($urandom_range(1, 16'h7FFF)) : DW'($urandom_range(16'h8000, 16'hFFFF));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, a, 3'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
